regfile_scoreboard: RTL

Scalar and vector register file with a per-register busy scoreboard, sitting in the decode stage directly downstream of the writeback stage. It commits writeback results, supplies source operands to decode with same-cycle write-through, and generates the dependence stall that decode broadcasts down the pipe as I_DepStall. Busy bits are set when decode issues a producing instruction and cleared when that register's result is written back.

---
 rtl/regfile_scoreboard.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - scalar/vector register file with busy scoreboard
// Write-through reads, RAW/WAW dependence stall and issue-time busy tracking.
module regfile_scoreboard #(
    parameter int NUM_SREG   = 16,
    parameter int NUM_VREG   = 16,
    parameter int REG_WIDTH  = 16,
    parameter int VREG_WIDTH = 64
) (
    input  logic                  I_CLOCK,
    input  logic                  I_RESET,
    input  logic                  I_LOCK,
    input  logic                  I_FetchStall,
    input  logic                  I_WriteBackEnable,
    input  logic                  I_VWriteBackEnable,
    input  logic [5:0]            I_WriteBackRegIdx,
    input  logic [REG_WIDTH-1:0]  I_WriteBackData,
    input  logic [VREG_WIDTH-1:0] I_VWriteBackData,
    input  logic                  I_IssueValid,
    input  logic [5:0]            I_IssueSrc1Idx,
    input  logic [5:0]            I_IssueSrc2Idx,
    input  logic [1:0]            I_IssueSrcUse,
    input  logic [1:0]            I_IssueSrcIsVec,
    input  logic [5:0]            I_IssueDestIdx,
    input  logic [1:0]            I_IssueDestKind,
    output logic [REG_WIDTH-1:0]  O_Src1Data,
    output logic [REG_WIDTH-1:0]  O_Src2Data,
    output logic [VREG_WIDTH-1:0] O_VSrc1Data,
    output logic [VREG_WIDTH-1:0] O_VSrc2Data,
    output logic                  O_DepStall,
    output logic                  O_IssueAccept,
    output logic                  O_Drained,
    output logic                  O_IdxError
);

    logic [REG_WIDTH-1:0]  sRegs [NUM_SREG];
    logic [VREG_WIDTH-1:0] vRegs [NUM_VREG];
    logic [NUM_SREG-1:0]   sBusy, sBusyEff, sBusyNext, sWbMask, sSetMask;
    logic [NUM_VREG-1:0]   vBusy, vBusyEff, vBusyNext, vWbMask, vSetMask;

    logic [3:0] wbIdx, src1Idx, src2Idx, destIdx;
    logic       wbLegal, src1Legal, src2Legal, destLegal;
    logic       sWbHit, vWbHit, sWbCommit, vWbCommit;
    logic       src1Busy, src2Busy, destBusy, depStall, issueAccept;

    assign wbIdx     = I_WriteBackRegIdx[3:0];
    assign src1Idx   = I_IssueSrc1Idx[3:0];
    assign src2Idx   = I_IssueSrc2Idx[3:0];
    assign destIdx   = I_IssueDestIdx[3:0];
    assign wbLegal   = (I_WriteBackRegIdx[5:4] == 2'b00);
    assign src1Legal = (I_IssueSrc1Idx[5:4] == 2'b00);
    assign src2Legal = (I_IssueSrc2Idx[5:4] == 2'b00);
    assign destLegal = (I_IssueDestIdx[5:4] == 2'b00);

    // Hits drive forwarding and effective busy; commits additionally need I_LOCK.
    assign sWbHit    = I_WriteBackEnable & wbLegal;
    assign vWbHit    = I_VWriteBackEnable & wbLegal;
    assign sWbCommit = I_LOCK & sWbHit;
    assign vWbCommit = I_LOCK & vWbHit;

    assign sWbMask  = sWbHit ? ({{(NUM_SREG-1){1'b0}}, 1'b1} << wbIdx) : '0;
    assign vWbMask  = vWbHit ? ({{(NUM_VREG-1){1'b0}}, 1'b1} << wbIdx) : '0;
    assign sBusyEff = sBusy & ~sWbMask;
    assign vBusyEff = vBusy & ~vWbMask;

    always_comb begin
        O_Src1Data = '0;
        if (src1Legal)
            O_Src1Data = (sWbHit && wbIdx == src1Idx) ? I_WriteBackData : sRegs[src1Idx];
    end

    always_comb begin
        O_Src2Data = '0;
        if (src2Legal)
            O_Src2Data = (sWbHit && wbIdx == src2Idx) ? I_WriteBackData : sRegs[src2Idx];
    end

    always_comb begin
        O_VSrc1Data = '0;
        if (src1Legal)
            O_VSrc1Data = (vWbHit && wbIdx == src1Idx) ? I_VWriteBackData : vRegs[src1Idx];
    end

    always_comb begin
        O_VSrc2Data = '0;
        if (src2Legal)
            O_VSrc2Data = (vWbHit && wbIdx == src2Idx) ? I_VWriteBackData : vRegs[src2Idx];
    end

    // Out-of-range indices never report busy; they carry no real register.
    always_comb begin
        src1Busy = 1'b0;
        src2Busy = 1'b0;
        destBusy = 1'b0;
        if (I_IssueSrcUse[0] && src1Legal)
            src1Busy = I_IssueSrcIsVec[0] ? vBusyEff[src1Idx] : sBusyEff[src1Idx];
        if (I_IssueSrcUse[1] && src2Legal)
            src2Busy = I_IssueSrcIsVec[1] ? vBusyEff[src2Idx] : sBusyEff[src2Idx];
        if (destLegal) begin
            if (I_IssueDestKind == 2'b01)
                destBusy = sBusyEff[destIdx];
            else if (I_IssueDestKind == 2'b10)
                destBusy = vBusyEff[destIdx];
        end
    end

    assign depStall      = I_LOCK & I_IssueValid & (src1Busy | src2Busy | destBusy);
    assign issueAccept   = I_LOCK & I_IssueValid & ~I_FetchStall & ~depStall;
    assign O_DepStall    = depStall;
    assign O_IssueAccept = issueAccept;
    assign O_Drained     = ~(|sBusy) & ~(|vBusy);

    always_comb begin
        sSetMask = '0;
        vSetMask = '0;
        if (issueAccept && destLegal) begin
            if (I_IssueDestKind == 2'b01)
                sSetMask = {{(NUM_SREG-1){1'b0}}, 1'b1} << destIdx;
            else if (I_IssueDestKind == 2'b10)
                vSetMask = {{(NUM_VREG-1){1'b0}}, 1'b1} << destIdx;
        end
    end

    // Set is OR-ed after the clear so a same-cycle issue keeps the bit busy.
    assign sBusyNext = (sBusy & ~(sWbCommit ? sWbMask : '0)) | sSetMask;
    assign vBusyNext = (vBusy & ~(vWbCommit ? vWbMask : '0)) | vSetMask;

    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_SREG; i++)
                sRegs[i] <= '0;
            for (int i = 0; i < NUM_VREG; i++)
                vRegs[i] <= '0;
            sBusy      <= '0;
            vBusy      <= '0;
            O_IdxError <= 1'b0;
        end else begin
            O_IdxError <= I_LOCK & (I_WriteBackEnable | I_VWriteBackEnable) & ~wbLegal;
            if (sWbCommit)
                sRegs[wbIdx] <= I_WriteBackData;
            if (vWbCommit)
                vRegs[wbIdx] <= I_VWriteBackData;
            sBusy <= sBusyNext;
            vBusy <= vBusyNext;
        end
    end

endmodule
